ext_avalon_burst_bridge: RTL and testbench

EXT_AVALON_BURST_BRIDGE -- requirements
Module: ext_avalon_burst_bridge

---
 rtl/ext_avalon_burst_bridge.sv | 146 ++++++++++++++
 tb/tb_ext_avalon_burst_bridge.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_avalon_burst_bridge.sv
// Bridges a level-handshake burst requester onto an Avalon-MM burst master port.
// Rejects illegal requests and aborts a transfer that stalls for too long.
module ext_avalon_burst_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int BURST_W = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_W-1:0]     ext_address,
   input  logic [DATA_W/8-1:0]   ext_byte_enable,
   input  logic                  ext_read,
   input  logic                  ext_write,
   input  logic [DATA_W-1:0]     ext_write_data,
   input  logic [BURST_W-1:0]    ext_burstcount,
   output logic                  ext_wr_ready,
   output logic [DATA_W-1:0]     ext_read_data,
   output logic                  ext_read_valid,
   output logic                  ext_acknowledge,
   output logic                  ext_error,
   output logic [ADDR_W-1:0]     avm_address,
   output logic [DATA_W/8-1:0]   avm_byteenable,
   output logic [BURST_W-1:0]    avm_burstcount,
   output logic                  avm_read,
   output logic                  avm_write,
   output logic [DATA_W-1:0]     avm_writedata,
   input  logic                  avm_waitrequest,
   input  logic [DATA_W-1:0]     avm_readdata,
   input  logic                  avm_readdatavalid
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RD_CMD  = 3'd1;
   localparam logic [2:0] RD_DATA = 3'd2;
   localparam logic [2:0] WR      = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;

   localparam int                 TMO_W    = $clog2(TIMEOUT + 1);
   localparam logic [BURST_W-1:0] ONE      = {{(BURST_W-1){1'b0}}, 1'b1};
   localparam logic [BURST_W-1:0] MAXB     = ONE << (BURST_W - 1);
   localparam logic [TMO_W-1:0]   TMO_ONE  = TMO_W'(1);
   localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT - 1);

   logic [2:0]          state;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W/8-1:0] be_q;
   logic [BURST_W-1:0]  burst_q;
   logic [BURST_W-1:0]  beat_cnt;
   logic [TMO_W-1:0]    tmo_cnt;
   logic                err_q;

   logic [BURST_W-1:0]  req_burst;
   logic                req_bad;
   logic                cmd_accept;
   logic                rd_beat;
   logic                rd_last;
   logic                wr_last;
   logic                tmo_hit;

   assign req_burst  = (ext_burstcount == '0) ? ONE : ext_burstcount;
   assign req_bad    = (ext_read && ext_write) || (req_burst > MAXB);
   assign cmd_accept = (state == RD_CMD) && !avm_waitrequest;
   // Zero-latency slaves may return data in the same cycle the command is accepted.
   assign rd_beat    = avm_readdatavalid && ((state == RD_CMD) || (state == RD_DATA));
   assign rd_last    = rd_beat && (beat_cnt == burst_q - ONE);
   assign wr_last    = ext_wr_ready && (beat_cnt == burst_q - ONE);
   assign tmo_hit    = (tmo_cnt == TMO_LAST);

   assign avm_address     = addr_q;
   assign avm_byteenable  = be_q;
   assign avm_burstcount  = burst_q;
   assign avm_read        = (state == RD_CMD);
   assign avm_write       = (state == WR);
   assign avm_writedata   = avm_write ? ext_write_data : '0;
   assign ext_wr_ready    = avm_write && !avm_waitrequest;
   assign ext_acknowledge = (state == DONE);
   assign ext_error       = ext_acknowledge && err_q;

   // NOTE: every register here is state that must read zero out of reset, so all use
   // non-blocking assignment inside a single async-reset block.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         addr_q         <= '0;
         be_q           <= '0;
         burst_q        <= '0;
         beat_cnt       <= '0;
         tmo_cnt        <= '0;
         err_q          <= 1'b0;
         ext_read_data  <= '0;
         ext_read_valid <= 1'b0;
      end else begin
         ext_read_valid <= rd_beat;
         if (rd_beat) ext_read_data <= avm_readdata;

         case (state)
            IDLE: begin
               beat_cnt <= '0;
               tmo_cnt  <= '0;
               err_q    <= 1'b0;
               if (ext_read || ext_write) begin
                  if (req_bad) begin
                     err_q <= 1'b1;
                     state <= DONE;
                  end else begin
                     addr_q  <= ext_address;
                     be_q    <= ext_byte_enable;
                     burst_q <= req_burst;
                     state   <= ext_read ? RD_CMD : WR;
                  end
               end
            end
            RD_CMD, RD_DATA: begin
               if (rd_beat) beat_cnt <= beat_cnt + ONE;
               if (rd_last) begin
                  state <= DONE;
               end else if (rd_beat || cmd_accept) begin
                  tmo_cnt <= '0;
                  if (cmd_accept) state <= RD_DATA;
               end else if (tmo_hit) begin
                  err_q <= 1'b1;
                  state <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_ONE;
               end
            end
            WR: begin
               if (ext_wr_ready) begin
                  beat_cnt <= beat_cnt + ONE;
                  tmo_cnt  <= '0;
                  if (wr_last) state <= DONE;
               end else if (tmo_hit) begin
                  err_q <= 1'b1;
                  state <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_ONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ext_avalon_burst_bridge.sv
// Randomized bench for ext_avalon_burst_bridge: a behavioural requester and Avalon slave
// drive traffic while beat counts, data order, latency and error flags are checked.
module tb_ext_avalon_burst_bridge;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int BW   = 4;
   localparam int BEW  = DW / 8;
   localparam int TMO  = 16;
   localparam int OV_W = 2 * DW + AW + BEW + BW + 6;

   logic           clk = 1'b0;
   logic           reset_n;
   logic [AW-1:0]  ext_address;
   logic [BEW-1:0] ext_byte_enable;
   logic           ext_read;
   logic           ext_write;
   logic [DW-1:0]  ext_write_data;
   logic [BW-1:0]  ext_burstcount;
   logic           ext_wr_ready;
   logic [DW-1:0]  ext_read_data;
   logic           ext_read_valid;
   logic           ext_acknowledge;
   logic           ext_error;
   logic [AW-1:0]  avm_address;
   logic [BEW-1:0] avm_byteenable;
   logic [BW-1:0]  avm_burstcount;
   logic           avm_read;
   logic           avm_write;
   logic [DW-1:0]  avm_writedata;
   logic           avm_waitrequest;
   logic [DW-1:0]  avm_readdata;
   logic           avm_readdatavalid;

   int tests_run    = 0;
   int tests_failed = 0;

   ext_avalon_burst_bridge #(
      .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .ext_address(ext_address), .ext_byte_enable(ext_byte_enable),
      .ext_read(ext_read), .ext_write(ext_write), .ext_write_data(ext_write_data),
      .ext_burstcount(ext_burstcount), .ext_wr_ready(ext_wr_ready),
      .ext_read_data(ext_read_data), .ext_read_valid(ext_read_valid),
      .ext_acknowledge(ext_acknowledge), .ext_error(ext_error),
      .avm_address(avm_address), .avm_byteenable(avm_byteenable),
      .avm_burstcount(avm_burstcount), .avm_read(avm_read), .avm_write(avm_write),
      .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
      .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [OV_W-1:0] outs();
      return {avm_read, avm_write, avm_address, avm_byteenable, avm_burstcount, avm_writedata,
              ext_wr_ready, ext_read_data, ext_read_valid, ext_acknowledge, ext_error};
   endfunction

   task automatic idle_inputs();
      ext_address = '0; ext_byte_enable = '0; ext_read = 1'b0; ext_write = 1'b0;
      ext_write_data = '0; ext_burstcount = '0;
      avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      ext_write_data = 32'hDEADBEEF;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (outs() !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %0h expected 0", outs());
      end
      // Request present at release must be taken on the very first edge.
      ext_read = 1'b1; ext_burstcount = 4'd1; ext_address = 32'h40;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      tests_run++;
      if (avm_read !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_first_edge: avm_read got %b expected 1", avm_read);
      end
      reset_n = 1'b0;
      idle_inputs();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input string name, input logic [AW-1:0] addr, input logic [BW-1:0] bc,
                          input int wait_cyc, input int gap_max, input int reset_beat,
                          input bit use_fixed, input logic [DW-1:0] fixed);
      int n, sent, got, rd_cycles, first_cmd, ack_cyc, last_rv, wcnt, gap;
      bit accepted, acked, err, cmd_bad, did_reset, exp_err;
      logic [DW-1:0]  exp_q[$];
      logic [DW-1:0]  d, e;
      logic [BEW-1:0] be;
      n = (bc == 0) ? 1 : int'(bc);
      exp_err = (wait_cyc >= TMO);
      sent = 0; got = 0; rd_cycles = 0; first_cmd = -1; ack_cyc = -1; last_rv = -1;
      wcnt = 0; gap = 0;
      accepted = 0; acked = 0; err = 0; cmd_bad = 0; did_reset = 0;
      be = BEW'($urandom);
      ext_address = addr; ext_byte_enable = be; ext_burstcount = bc; ext_read = 1'b1;
      for (int cyc = 0; cyc < 300 && !acked && !did_reset; cyc++) begin
         avm_waitrequest = 1'b0;
         avm_readdatavalid = 1'b0;
         if (avm_read && !accepted) begin
            if (wcnt < wait_cyc) begin
               avm_waitrequest = 1'b1;
               wcnt++;
            end else begin
               accepted = 1;
            end
         end
         if (accepted && sent < n) begin
            if (gap > 0) begin
               gap--;
            end else if (sent == reset_beat) begin
               reset_n = 1'b0;
               #1;
               tests_run++;
               if (outs() !== '0) begin
                  tests_failed++;
                  $display("FAIL %s_reset_outputs: got %0h expected 0", name, outs());
               end
               idle_inputs();
               @(negedge clk);
               reset_n = 1'b1;
               @(posedge clk);
               #1;
               did_reset = 1;
            end else begin
               d = use_fixed ? fixed : DW'($urandom);
               avm_readdata = d;
               avm_readdatavalid = 1'b1;
               exp_q.push_back(d);
               sent++;
               gap = $urandom_range(0, gap_max);
            end
         end
         if (!did_reset) begin
            @(negedge clk);
            if (avm_read) begin
               rd_cycles++;
               if (first_cmd < 0) first_cmd = cyc;
               if (avm_address !== addr || avm_burstcount !== BW'(n) || avm_byteenable !== be)
                  cmd_bad = 1;
            end
            if (ext_read_valid) begin
               got++;
               last_rv = cyc;
               e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
               tests_run++;
               if (ext_read_data !== e) begin
                  tests_failed++;
                  $display("FAIL %s_data: got %0h expected %0h", name, ext_read_data, e);
               end
            end
            if (ext_acknowledge) begin
               acked = 1;
               ack_cyc = cyc;
               err = ext_error;
            end
            @(posedge clk);
            #1;
         end
      end
      ext_read = 1'b0;
      avm_waitrequest = 1'b0;
      avm_readdatavalid = 1'b0;
      if (!did_reset) begin
         tests_run++;
         if (!acked || err !== exp_err) begin
            tests_failed++;
            $display("FAIL %s_ack: ack %b error %b expected ack 1 error %b", name, acked, err, exp_err);
         end
         tests_run++;
         if (got != (exp_err ? 0 : n)) begin
            tests_failed++;
            $display("FAIL %s_beats: got %0d expected %0d", name, got, exp_err ? 0 : n);
         end
         tests_run++;
         if (first_cmd != 1 || cmd_bad) begin
            tests_failed++;
            $display("FAIL %s_cmd: first cycle %0d bad %b expected 1 and 0", name, first_cmd, cmd_bad);
         end
         tests_run++;
         if (exp_err ? (rd_cycles != TMO) : (ack_cyc != last_rv)) begin
            tests_failed++;
            $display("FAIL %s_timing: read cycles %0d ack %0d last valid %0d", name, rd_cycles,
                     ack_cyc, last_rv);
         end
      end
   endtask

   task automatic do_write(input string name, input logic [AW-1:0] addr, input logic [BW-1:0] bc,
                           input bit directed);
      logic [DW-1:0]  wd[$];
      logic [BEW-1:0] be;
      int n, idx, first_cmd, ack_cyc, last_rdy, run;
      bit acked, err, cmd_bad, tog;
      n = (bc == 0) ? 1 : int'(bc);
      for (int i = 0; i < n; i++) wd.push_back(directed ? DW'(i + 1) : DW'($urandom));
      idx = 0; first_cmd = -1; ack_cyc = -1; last_rdy = -1; run = 0;
      acked = 0; err = 0; cmd_bad = 0; tog = 0;
      be = BEW'($urandom);
      ext_address = addr; ext_byte_enable = be; ext_burstcount = bc; ext_write = 1'b1;
      for (int cyc = 0; cyc < 300 && !acked; cyc++) begin
         ext_write_data = (idx < n) ? wd[idx] : '0;
         avm_waitrequest = 1'b0;
         if (avm_write) begin
            if (directed) begin
               tog = !tog;
               avm_waitrequest = tog;
            end else if (run < 3 && $urandom_range(0, 1) == 1) begin
               avm_waitrequest = 1'b1;
               run++;
            end else begin
               run = 0;
            end
         end
         @(negedge clk);
         if (avm_write) begin
            if (first_cmd < 0) first_cmd = cyc;
            if (avm_address !== addr || avm_burstcount !== BW'(n) || avm_byteenable !== be)
               cmd_bad = 1;
         end
         if (ext_wr_ready) begin
            tests_run++;
            if (idx >= n || avm_writedata !== wd[idx]) begin
               tests_failed++;
               $display("FAIL %s_wdata: beat %0d got %0h expected %0h", name, idx, avm_writedata,
                        (idx < n) ? wd[idx] : 'x);
            end
            idx++;
            last_rdy = cyc;
         end
         if (ext_acknowledge) begin
            acked = 1;
            ack_cyc = cyc;
            err = ext_error;
         end
         @(posedge clk);
         #1;
      end
      ext_write = 1'b0;
      avm_waitrequest = 1'b0;
      tests_run++;
      if (!acked || err !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s_ack: ack %b error %b expected ack 1 error 0", name, acked, err);
      end
      tests_run++;
      if (idx != n) begin
         tests_failed++;
         $display("FAIL %s_ready_count: got %0d expected %0d", name, idx, n);
      end
      tests_run++;
      if (first_cmd != 1 || cmd_bad || ack_cyc != last_rdy + 1) begin
         tests_failed++;
         $display("FAIL %s_cmd: first %0d bad %b ack %0d last ready %0d", name, first_cmd, cmd_bad,
                  ack_cyc, last_rdy);
      end
   endtask

   task automatic do_illegal(input string name, input bit rd, input bit wr, input logic [BW-1:0] bc);
      int ack_cyc;
      bit cmd_seen, err;
      ack_cyc = -1; cmd_seen = 0; err = 0;
      ext_address = 32'h300; ext_byte_enable = '1; ext_burstcount = bc;
      ext_read = rd; ext_write = wr;
      for (int cyc = 0; cyc < 10 && ack_cyc < 0; cyc++) begin
         @(negedge clk);
         if (avm_read || avm_write) cmd_seen = 1;
         if (ext_acknowledge) begin
            ack_cyc = cyc;
            err = ext_error;
         end
         @(posedge clk);
         #1;
      end
      ext_read = 1'b0;
      ext_write = 1'b0;
      tests_run++;
      if (ack_cyc != 1 || err !== 1'b1 || cmd_seen) begin
         tests_failed++;
         $display("FAIL %s: ack cycle %0d error %b command %b expected 1 1 0", name, ack_cyc, err,
                  cmd_seen);
      end
   endtask

   task automatic test_stray_valid();
      bit seen;
      seen = 0;
      for (int i = 0; i < 3; i++) begin
         avm_readdatavalid = 1'b1;
         avm_readdata = DW'($urandom);
         @(negedge clk);
         if (ext_read_valid) seen = 1;
         @(posedge clk);
         #1;
      end
      avm_readdatavalid = 1'b0;
      @(negedge clk);
      if (ext_read_valid) seen = 1;
      @(posedge clk);
      #1;
      tests_run++;
      if (seen) begin
         tests_failed++;
         $display("FAIL stray_valid: ext_read_valid got 1 expected 0");
      end
   endtask

   task automatic test_single_read();
      do_read("single_read", 32'h100, 4'd0, 2, 0, -1, 1'b1, 32'hCAFEF00D);
   endtask

   task automatic test_burst_write();
      do_write("burst_write", 32'h2000, 4'd4, 1'b1);
   endtask

   task automatic test_illegal();
      do_illegal("illegal_rd_wr", 1'b1, 1'b1, 4'd2);
      do_illegal("illegal_burst9", 1'b1, 1'b0, 4'd9);
      do_read("max_burst_read", 32'h500, 4'd8, 0, 0, -1, 1'b0, '0);
   endtask

   task automatic test_timeout();
      do_read("timeout_read", 32'h600, 4'd1, 1000, 0, -1, 1'b0, '0);
      do_read("after_timeout", 32'h604, 4'd2, 1, 2, -1, 1'b0, '0);
   endtask

   task automatic test_reset_mid_burst();
      do_read("mid_reset", 32'h700, 4'd4, 1, 1, 1, 1'b0, '0);
      do_read("after_reset", 32'h710, 4'd4, 0, 1, -1, 1'b0, '0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) begin
         if ($urandom_range(0, 1) == 1)
            do_read("rand_read", AW'($urandom), BW'($urandom_range(0, 8)),
                    $urandom_range(0, 4), 3, -1, 1'b0, '0);
         else
            do_write("rand_write", AW'($urandom), BW'($urandom_range(0, 8)), 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_burst_write();
      test_illegal();
      test_stray_valid();
      test_timeout();
      test_reset_mid_burst();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
